// File: rtl/elevator_ctrl_n_pkg.sv
// Shared encodings for the elevator controller: FSM states and travel direction.
package elevator_ctrl_n_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MV_UP = 2'd1,
    MV_DN = 2'd2,
    DOOR  = 2'd3
  } state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;
endpackage

// File: rtl/elevator_ctrl_n_req_bank.sv
// Hall-up, hall-down and car-call latch vectors (clear applied before set),
// plus "any request strictly above/below floor_i" reductions.
module elevator_ctrl_n_req_bank #(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] set_up_i,
  input  logic [N_FLOORS-1:0] set_dn_i,
  input  logic [N_FLOORS-1:0] set_car_i,
  input  logic [N_FLOORS-1:0] clr_up_i,
  input  logic [N_FLOORS-1:0] clr_dn_i,
  input  logic [N_FLOORS-1:0] clr_car_i,
  input  logic [FLOOR_W-1:0]  floor_i,
  output logic [N_FLOORS-1:0] up_o,
  output logic [N_FLOORS-1:0] dn_o,
  output logic [N_FLOORS-1:0] car_o,
  output logic [N_FLOORS-1:0] pending_o,
  output logic                above_o,
  output logic                below_o
);
  logic [N_FLOORS-1:0] up_q, up_d;
  logic [N_FLOORS-1:0] dn_q, dn_d;
  logic [N_FLOORS-1:0] car_q, car_d;

  // The top masks each set vector so that only the intended winner survives.
  always_comb begin
    up_d  = (up_q  & ~clr_up_i)  | set_up_i;
    dn_d  = (dn_q  & ~clr_dn_i)  | set_dn_i;
    car_d = (car_q & ~clr_car_i) | set_car_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      up_q  <= '0;
      dn_q  <= '0;
      car_q <= '0;
    end else begin
      up_q  <= up_d;
      dn_q  <= dn_d;
      car_q <= car_d;
    end
  end

  assign up_o      = up_q;
  assign dn_o      = dn_q;
  assign car_o     = car_q;
  assign pending_o = up_q | dn_q | car_q;

  always_comb begin
    above_o = 1'b0;
    below_o = 1'b0;
    for (int f = 0; f < N_FLOORS; f++) begin
      if (pending_o[f] && (f > int'(floor_i))) above_o = 1'b1;
      if (pending_o[f] && (f < int'(floor_i))) below_o = 1'b1;
    end
  end
endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor collective elevator controller: request latching, position tracking from
// one-hot floor sensors, registered motor/door commands and a reloadable door dwell.
module elevator_ctrl_n
  import elevator_ctrl_n_pkg::*;
#(
  parameter  int N_FLOORS    = 4,
  parameter  int DOOR_CYCLES = 8,
  localparam int FLOOR_W     = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] floor_sensor,
  input  logic [N_FLOORS-1:0] hall_up,
  input  logic [N_FLOORS-1:0] hall_dn,
  input  logic [N_FLOORS-1:0] car_call,
  output logic                up,
  output logic                down,
  output logic                stop,
  output logic                open_door,
  output logic [FLOOR_W-1:0]  monitor,
  output logic [N_FLOORS-1:0] pending,
  output logic                sensor_err
);
  localparam int                  TMR_W   = $clog2(DOOR_CYCLES + 1);
  localparam logic [TMR_W-1:0]    TMR_LD  = TMR_W'(DOOR_CYCLES);
  localparam logic [TMR_W-1:0]    TMR_ONE = TMR_W'(1);
  localparam logic [N_FLOORS-1:0] ONE     = {{(N_FLOORS-1){1'b0}}, 1'b1};
  localparam logic [N_FLOORS-1:0] UP_MSK  = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MSK  = {{(N_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FLOOR_W-1:0]  TOP_F   = FLOOR_W'(N_FLOORS - 1);
  localparam logic [FLOOR_W-1:0]  BOT_F   = '0;

  state_e              state_q, state_d;
  dir_e                dir_q, dir_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [FLOOR_W-1:0]  monitor_q;
  logic                err_q;
  logic                up_q, down_q, stop_q, open_q;

  logic [FLOOR_W-1:0]  sens_idx, cur_f;
  logic                sens_any, sens_vld, sens_multi;
  logic [N_FLOORS-1:0] hup, hdn, cur_oh;
  logic [N_FLOORS-1:0] req_up, req_dn, req_car;
  logic                above, below;
  logic                clr_up_b, clr_dn_b, serve_here, hit_up, hit_dn, press_here;
  logic                entry;
  logic [N_FLOORS-1:0] clr_up, clr_dn, clr_car, blk;

  assign hup = hall_up & UP_MSK;
  assign hdn = hall_dn & DN_MSK;

  always_comb begin
    sens_idx = '0;
    for (int f = 0; f < N_FLOORS; f++) begin
      if (floor_sensor[f]) sens_idx = FLOOR_W'(f);
    end
  end

  assign sens_any   = |floor_sensor;
  assign sens_vld   = sens_any && ((floor_sensor & (floor_sensor - ONE)) == '0);
  assign sens_multi = sens_any && !sens_vld;
  assign cur_f      = sens_vld ? sens_idx : monitor_q;
  assign cur_oh     = ONE << cur_f;

  // Opposite-direction hall call is served only when nothing lies beyond in dir.
  assign clr_up_b   = (dir_q == DIR_UP) || !below;
  assign clr_dn_b   = (dir_q == DIR_DN) || !above;
  assign serve_here = |(req_car & cur_oh) | (|(req_up & cur_oh) & clr_up_b)
                    | (|(req_dn & cur_oh) & clr_dn_b);
  assign hit_up     = |((req_car | car_call | req_up | hup) & cur_oh);
  assign hit_dn     = |((req_car | car_call | req_dn | hdn) & cur_oh);
  assign press_here = |((car_call | hup | hdn) & cur_oh);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        // Only calls this stop would actually clear may open the door; otherwise
        // an opposite hall call with work beyond it would reopen the door forever.
        if (sens_vld && serve_here) begin
          state_d = DOOR;
        end else if (dir_q == DIR_UP && above) begin
          state_d = MV_UP;
        end else if (below) begin
          state_d = MV_DN;
          dir_d   = DIR_DN;
        end else if (above) begin
          state_d = MV_UP;
          dir_d   = DIR_UP;
        end
      end
      MV_UP: begin
        if (sens_vld && (hit_up || !above || cur_f == TOP_F)) state_d = DOOR;
      end
      MV_DN: begin
        if (sens_vld && (hit_dn || !below || cur_f == BOT_F)) state_d = DOOR;
      end
      DOOR: begin
        if (press_here) begin
          timer_d = TMR_LD;
        end else if (timer_q <= TMR_ONE) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == DOOR && state_q != DOOR) timer_d = TMR_LD;
  end

  assign entry   = (state_d == DOOR) && (state_q != DOOR);
  assign clr_car = entry ? cur_oh : '0;
  assign clr_up  = (entry && clr_up_b) ? cur_oh : '0;
  assign clr_dn  = (entry && clr_dn_b) ? cur_oh : '0;
  assign blk     = (state_q == DOOR) ? cur_oh : '0;

  elevator_ctrl_n_req_bank #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_req_bank (
    .clk       (clk),
    .reset     (reset),
    .set_up_i  (hup & ~clr_up & ~blk),
    .set_dn_i  (hdn & ~clr_dn & ~blk),
    .set_car_i (car_call & ~clr_car & ~blk),
    .clr_up_i  (clr_up),
    .clr_dn_i  (clr_dn),
    .clr_car_i (clr_car),
    .floor_i   (cur_f),
    .up_o      (req_up),
    .dn_o      (req_dn),
    .car_o     (req_car),
    .pending_o (pending),
    .above_o   (above),
    .below_o   (below)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      dir_q     <= DIR_UP;
      timer_q   <= '0;
      monitor_q <= '0;
      err_q     <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      stop_q    <= 1'b1;
      open_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      monitor_q <= sens_vld ? sens_idx : monitor_q;
      err_q     <= err_q | sens_multi;
      up_q      <= (state_d == MV_UP);
      down_q    <= (state_d == MV_DN);
      stop_q    <= (state_d != MV_UP) && (state_d != MV_DN);
      open_q    <= (state_d == DOOR);
    end
  end

  assign up         = up_q;
  assign down       = down_q;
  assign stop       = stop_q;
  assign open_door  = open_q;
  assign monitor    = monitor_q;
  assign sensor_err = err_q;
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Bench for elevator_ctrl_n: sensor/latch vector table, directed multi-cycle
// sequences on a simple car plant, then random calls against a request model.
module tb_elevator_ctrl_n;
  localparam int NF = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] floor_sensor, hall_up, hall_dn, car_call;
  logic          up, down, stop, open_door, sensor_err;
  logic [1:0]    monitor;
  logic [NF-1:0] pending;

  int total = 0;
  int bad   = 0;
  int pos   = 0;
  bit plant_en = 1'b0;
  bit ovr      = 1'b0;

  typedef struct {
    logic [NF-1:0] sens;
    logic [NF-1:0] hup;
    logic [NF-1:0] hdn;
    logic [1:0]    mon;
    logic          err;
    logic [NF-1:0] pend;
  } vec_t;

  elevator_ctrl_n #(.N_FLOORS(NF), .DOOR_CYCLES(DC)) dut (
    .clk          (clk),
    .reset        (reset),
    .floor_sensor (floor_sensor),
    .hall_up      (hall_up),
    .hall_dn      (hall_dn),
    .car_call     (car_call),
    .up           (up),
    .down         (down),
    .stop         (stop),
    .open_door    (open_door),
    .monitor      (monitor),
    .pending      (pending),
    .sensor_err   (sensor_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Car plant: 4 ticks per floor, sensor lit only when exactly at a floor.
  task automatic update_sensor();
    if (plant_en) floor_sensor = (pos % 4 == 0) ? NF'(1 << (pos / 4)) : '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    if (plant_en) begin
      if (up) begin
        if (pos >= 4 * (NF - 1)) ovr = 1'b1;
        else pos++;
      end else if (down) begin
        if (pos <= 0) ovr = 1'b1;
        else pos--;
      end
    end
    update_sensor();
  endtask

  task automatic do_reset(input int p);
    reset = 1'b1;
    hall_up = '0; hall_dn = '0; car_call = '0;
    pos = p; plant_en = 1'b1; ovr = 1'b0;
    update_sensor();
    cyc(); cyc();
    reset = 1'b0;
    cyc();
  endtask

  initial begin
    vec_t tbl [11];
    int   n, m, mon_exp;
    bit   pend_ok;
    int   q [$];
    logic prev_open;
    logic [NF-1:0] s, pv;

    tbl[0]  = '{4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 4'b0000};
    tbl[3]  = '{4'b1000, 4'b0000, 4'b0000, 2'd3, 1'b0, 4'b0000};
    tbl[4]  = '{4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b0, 4'b0000};
    tbl[5]  = '{4'b0001, 4'b1000, 4'b0000, 2'd0, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 4'b0000};
    tbl[7]  = '{4'b0110, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'b0000};
    tbl[9]  = '{4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1, 4'b0000};
    tbl[10] = '{4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1, 4'b0000};

    reset = 1'b1;
    hall_up = '0; hall_dn = '0; car_call = '0;
    floor_sensor = 4'b0001;
    cyc(); cyc();
    chk("rst_stop", 32'(stop), 1);
    chk("rst_up", 32'(up), 0);
    chk("rst_down", 32'(down), 0);
    chk("rst_door", 32'(open_door), 0);
    chk("rst_monitor", 32'(monitor), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_err", 32'(sensor_err), 0);
    reset = 1'b0;
    cyc();
    chk("idle_stop", 32'(stop), 1);

    for (int i = 0; i < 11; i++) begin
      floor_sensor = tbl[i].sens;
      hall_up = tbl[i].hup;
      hall_dn = tbl[i].hdn;
      cyc();
      hall_up = '0; hall_dn = '0;
      chk($sformatf("tbl%0d_monitor", i), 32'(monitor), 32'(tbl[i].mon));
      chk($sformatf("tbl%0d_err", i), 32'(sensor_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_stop", i), 32'(stop), 1);
    end

    // Reset while travelling up, with sensor_err still set from the table.
    pos = 0; plant_en = 1'b1; update_sensor();
    car_call = 4'b1000; cyc(); car_call = '0;
    n = 0;
    while (!up && n < 10) begin cyc(); n++; end
    chk("mid_up_started", 32'(up), 1);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    chk("mid_rst_stop", 32'(stop), 1);
    chk("mid_rst_up", 32'(up), 0);
    chk("mid_rst_pending", 32'(pending), 0);
    chk("mid_rst_err", 32'(sensor_err), 0);
    reset = 1'b0;

    // Single call from floor 0 to floor 2.
    do_reset(0);
    car_call = 4'b0100; cyc(); car_call = '0;
    chk("c2_pending", 32'(pending), 32'h4);
    cyc();
    chk("c2_up", 32'(up), 1);
    n = 0;
    while (!open_door && n < 40) begin cyc(); n++; end
    chk("c2_arrived", 32'(open_door), 1);
    chk("c2_monitor", 32'(monitor), 2);
    chk("c2_stop", 32'(stop), 1);
    chk("c2_pending_clr", 32'(pending), 0);
    n = 1;
    while (open_door && n < 20) begin cyc(); if (open_door) n++; end
    chk("c2_door_len", n, DC);
    chk("c2_closed_stop", 32'(stop), 1);

    // Door reload: press the car button at floor 2 on the last open cycle.
    car_call = 4'b0100; cyc(); car_call = '0;
    n = 0;
    while (!open_door && n < 20) begin cyc(); n++; end
    chk("rl_open", 32'(open_door), 1);
    cyc(); cyc(); cyc();
    chk("rl_still_open", 32'(open_door), 1);
    car_call = 4'b0100; cyc(); car_call = '0;
    m = 0; pend_ok = 1'b1;
    while (open_door && m < 20) begin
      if (pending[2]) pend_ok = 1'b0;
      m++;
      cyc();
    end
    chk("rl_len", m, DC);
    chk("rl_pend2", 32'(pend_ok), 1);

    // Collective: hall_dn[1] + car_call[3] from floor 0 -> stop at 3, then 1.
    do_reset(0);
    hall_dn = 4'b0010; car_call = 4'b1000; cyc(); hall_dn = '0; car_call = '0;
    prev_open = 1'b0;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (open_door && !prev_open) q.push_back(int'(monitor));
      prev_open = open_door;
    end
    chk("coll_stops", q.size(), 2);
    chk("coll_first", (q.size() > 0) ? q[0] : -1, 3);
    chk("coll_second", (q.size() > 1) ? q[1] : -1, 1);
    chk("coll_pending", 32'(pending), 0);

    // Random calls: latching, position, motor sanity, then full drain.
    do_reset(0);
    mon_exp = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 2))
          0: car_call[$urandom_range(0, NF - 1)] = 1'b1;
          1: hall_up[$urandom_range(0, NF - 1)] = 1'b1;
          default: hall_dn[$urandom_range(0, NF - 1)] = 1'b1;
        endcase
      end
      s = floor_sensor;
      pv = (car_call | (hall_up & 4'b0111) | (hall_dn & 4'b1110)) & ~s;
      if ($onehot(s)) for (int f = 0; f < NF; f++) if (s[f]) mon_exp = f;
      cyc();
      car_call = '0; hall_up = '0; hall_dn = '0;
      chk("rnd_motor_onehot", $countones({up, down, stop}), 1);
      chk("rnd_door_stop", 32'(open_door && !stop), 0);
      chk("rnd_monitor", 32'(monitor), mon_exp);
      chk("rnd_latch", 32'(pending & pv), 32'(pv));
      chk("rnd_overrun", 32'(ovr), 0);
    end
    chk("rnd_err", 32'(sensor_err), 0);
    n = 0;
    while (!(pending == '0 && stop && !open_door) && n < 800) begin cyc(); n++; end
    chk("drain_pending", 32'(pending), 0);
    chk("drain_idle", 32'(stop && !open_door), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
